// File: rtl/branch_pkg.sv
// Shared types and helpers for the sequential branch comparator.
//   funct3_e : RV32I branch funct3 encodings
//   state_e  : comparator FSM states
//   is_signed_cmp / branch_taken : funct3 decode helpers
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed compare only for BEQ/BNE/BLT/BGE. BLTU/BGEU and the illegal
    // codes 010/011 compare unsigned.
    function automatic logic is_signed_cmp(input logic [2:0] f3);
        return (f3[1] == 1'b0);
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq_i,
                                          input logic lt_i);
        logic t;
        t = 1'b0;
        case (f3)
            BEQ:        t = eq_i;
            BNE:        t = !eq_i;
            BLT, BLTU:  t = lt_i;
            BGE, BGEU:  t = !lt_i;
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit comparator.
//   a, b     : chunk operands
//   flip_msb : invert both MSBs first, turning a signed compare into unsigned
//   ceq      : a == b
//   clt      : a < b (after optional MSB flip)
module chunk_cmp #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             ceq,
    output logic             clt
);

    localparam logic [CHUNK-1:0] MsbMask = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] ax;
    logic [CHUNK-1:0] bx;

    always_comb begin
        ax  = flip_msb ? (a ^ MsbMask) : a;
        bx  = flip_msb ? (b ^ MsbMask) : b;
        ceq = (a == b);
        clt = (ax < bx);
    end

endmodule

// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: compares data1/data2 CHUNK bits per cycle from
// the MSB chunk down, stopping at the first differing chunk, and decodes funct3
// into a taken decision.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (accepted only in IDLE)
//   data1, data2, funct3: operands and RV32I branch type
//   out_valid/out_ready : result handshake
//   eq, lt, taken       : comparison results and branch decision
//   illegal             : funct3 is 010 or 011
module branch_comp_seq
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             taken,
    output logic             illegal
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] TopIdx = IdxW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  d1_q, d1_d;
    logic [WIDTH-1:0]  d2_q, d2_d;
    logic [2:0]        f3_q, f3_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;

    logic [CHUNK-1:0]  ca, cb;
    logic              flip;
    logic              ceq, clt;

    // Single comparator shared across chunks; the index selects its operands.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IdxW'(i)) begin
                ca = d1_q[i*CHUNK +: CHUNK];
                cb = d2_q[i*CHUNK +: CHUNK];
            end
        end
        flip = is_signed_cmp(f3_q) && (idx_q == TopIdx);
    end

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a        (ca),
        .b        (cb),
        .flip_msb (flip),
        .ceq      (ceq),
        .clt      (clt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        f3_d      = f3_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d1_d    = data1;
                    d2_d    = data2;
                    f3_d    = funct3;
                    idx_d   = TopIdx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!ceq) begin
                    eq_d      = 1'b0;
                    lt_d      = clt;
                    taken_d   = branch_taken(f3_q, 1'b0, clt);
                    illegal_d = is_illegal(f3_q);
                    state_d   = DONE;
                end else if (idx_q == '0) begin
                    eq_d      = 1'b1;
                    lt_d      = 1'b0;
                    taken_d   = branch_taken(f3_q, 1'b1, 1'b0);
                    illegal_d = is_illegal(f3_q);
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            f3_q      <= '0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            f3_q      <= f3_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;

endmodule
